// File: rtl/gene_merge_fifo_pkg.sv
// Shared constants and helpers for the gene merge FIFO slice.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package gene_merge_fifo_pkg;

  localparam int LANE_CNT       = 3;   // lanes produced per cycle by the PE
  localparam int AF_FREE_THRESH = 3;   // almost_full while free entries < this
  localparam int STAT_CNT_W     = 16;  // width of the statistics counters

  // Saturating add of a small lane count onto a statistics counter.
  function automatic logic [STAT_CNT_W-1:0] sat_add(input logic [STAT_CNT_W-1:0] a,
                                                    input logic [1:0]            b);
    logic [STAT_CNT_W:0] s;
    s = {1'b0, a} + {{(STAT_CNT_W-1){1'b0}}, b};
    return s[STAT_CNT_W] ? {STAT_CNT_W{1'b1}} : s[STAT_CNT_W-1:0];
  endfunction

endpackage

// File: rtl/gene_lane_compactor.sv
// Packs the valid lanes of a sparse 3-lane group into consecutive low slots.
// Latency: combinational, zero cycles.
// Backpressure: none; the caller decides whether the packed group is kept.
// Ports: in_valid/gene_in1..3 = sparse lanes; n = valid lane count;
//        slot_dat/slot_vld = packed genes, slot 0 first in stream order.
module gene_lane_compactor
  import gene_merge_fifo_pkg::*;
#(
  parameter int GENE_SZ = 64
) (
  input  logic [LANE_CNT-1:0]              in_valid,
  input  logic [GENE_SZ-1:0]               gene_in1,
  input  logic [GENE_SZ-1:0]               gene_in2,
  input  logic [GENE_SZ-1:0]               gene_in3,
  output logic [1:0]                       n,
  output logic [LANE_CNT-1:0][GENE_SZ-1:0] slot_dat,
  output logic [LANE_CNT-1:0]              slot_vld
);

  logic [LANE_CNT-1:0][GENE_SZ-1:0] lane_dat;
  logic [1:0]                       idx;

  assign lane_dat = {gene_in3, gene_in2, gene_in1};

  // Walk lanes in order; each valid lane lands in the next free slot.
  always_comb begin
    slot_dat = '0;
    slot_vld = '0;
    idx      = 2'd0;
    for (int k = 0; k < LANE_CNT; k++) begin
      if (in_valid[k]) begin
        slot_dat[idx] = lane_dat[k];
        slot_vld[idx] = 1'b1;
        idx           = idx + 2'd1;
      end
    end
    n = idx;
  end

endmodule

// File: rtl/gene_merge_fifo.sv
// Merges 0-3 child genes per cycle into one in-order stream via a circular buffer.
// Latency: a gene written in cycle N is visible on out_gene/out_valid in cycle N+1.
// Backpressure: producer cannot stall; almost_full warns, a group that does not fit is dropped whole and sets overflow.
// Ports: clk/rst (async active-high), clear (sync flush), gene_in1..3 + in_valid (sparse lanes),
//        out_gene/out_valid/out_ready (stream), almost_full, overflow (sticky), fill_level, gene_count,
//        drop_count (only when GENE_MERGE_DROP_STATS_EN is defined).
module gene_merge_fifo
  import gene_merge_fifo_pkg::*;
#(
  parameter int GENE_SZ = 64,
  parameter int DEPTH   = 16,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int CNT_W  = PTR_W + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic [GENE_SZ-1:0]    gene_in1,
  input  logic [GENE_SZ-1:0]    gene_in2,
  input  logic [GENE_SZ-1:0]    gene_in3,
  input  logic [LANE_CNT-1:0]   in_valid,
  output logic [GENE_SZ-1:0]    out_gene,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  almost_full,
  output logic                  overflow,
  output logic [CNT_W-1:0]      fill_level,
`ifdef GENE_MERGE_DROP_STATS_EN
  output logic [STAT_CNT_W-1:0] drop_count,
`endif
  output logic [STAT_CNT_W-1:0] gene_count
);

  logic [GENE_SZ-1:0]               mem [DEPTH];
  logic [PTR_W-1:0]                 wr_ptr, rd_ptr;
  logic [CNT_W-1:0]                 cnt;

  logic [1:0]                       n;
  logic [LANE_CNT-1:0][GENE_SZ-1:0] slot_dat;
  logic [LANE_CNT-1:0]              slot_vld;

  logic [CNT_W-1:0]                 free_cnt;
  logic                             fits, push_vld, drop_vld, pop_vld;
  logic [1:0]                       n_acc;

  gene_lane_compactor #(.GENE_SZ(GENE_SZ)) u_compactor (
    .in_valid (in_valid),
    .gene_in1 (gene_in1),
    .gene_in2 (gene_in2),
    .gene_in3 (gene_in3),
    .n        (n),
    .slot_dat (slot_dat),
    .slot_vld (slot_vld)
  );

  // Space is judged on start-of-cycle occupancy; a same-cycle pop earns no credit.
  assign free_cnt = CNT_W'(DEPTH) - cnt;
  assign fits     = CNT_W'(n) <= free_cnt;
  assign push_vld = !clear && (n != 2'd0) && fits;
  assign drop_vld = !clear && (n != 2'd0) && !fits;
  assign pop_vld  = !clear && (cnt != '0) && out_ready;
  assign n_acc    = push_vld ? n : 2'd0;

  assign out_valid   = (cnt != '0);
  assign out_gene    = out_valid ? mem[rd_ptr] : '0;
  assign fill_level  = cnt;
  assign almost_full = free_cnt < CNT_W'(AF_FREE_THRESH);

  // Storage is deliberately left unreset; occupancy alone defines what is live.
  always_ff @(posedge clk) begin
    if (push_vld) begin
      for (int k = 0; k < LANE_CNT; k++) begin
        if (slot_vld[k]) mem[wr_ptr + PTR_W'(k)] <= slot_dat[k];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      cnt        <= '0;
      overflow   <= 1'b0;
      gene_count <= '0;
    end else if (clear) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      cnt        <= '0;
      overflow   <= 1'b0;
      gene_count <= '0;
    end else begin
      wr_ptr     <= wr_ptr + PTR_W'(n_acc);
      rd_ptr     <= rd_ptr + PTR_W'(pop_vld);
      cnt        <= cnt + CNT_W'(n_acc) - CNT_W'(pop_vld);
      gene_count <= sat_add(gene_count, n_acc);
      if (drop_vld) overflow <= 1'b1;
    end
  end

`ifdef GENE_MERGE_DROP_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_count <= '0;
    end else if (clear) begin
      drop_count <= '0;
    end else if (drop_vld) begin
      drop_count <= sat_add(drop_count, n);
    end
  end
`endif

endmodule
